alarm_ringer: RTL and testbench

Downstream consumer of the alarm comparator's `alarm_trigger` level. It converts a trigger rising edge into a timed ringing session that drives the buzzer with a 1 Hz on/off pattern. The user can snooze the session a bounded number of times or stop it; unanswered sessions time out and raise a missed flag. The block runs in the 1 Hz clock domain and sits between the alarm comparator and the buzzer/LED drivers.

---
 rtl/alarm_ringer_if.sv | 22 ++
 rtl/alarm_ringer.sv | 138 +++++++++++++
 tb/tb_alarm_ringer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm comparator/user buttons and the ringer,
// plus the buzzer/LED-side status outputs.
interface alarm_ringer_if;
    logic       alarm_trigger;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [2:0] snooze_count;
    logic       alarm_missed;

    modport master (
        output alarm_trigger, snooze_btn, stop_btn,
        input  buzzer, ringing, snoozing, snooze_count, alarm_missed
    );

    modport slave (
        input  alarm_trigger, snooze_btn, stop_btn,
        output buzzer, ringing, snoozing, snooze_count, alarm_missed
    );
endinterface

// File: rtl/alarm_ringer.sv
// Turns an alarm_trigger rising edge into a timed ringing session with a 1 Hz
// buzzer pattern, bounded snoozes, stop, and a sticky missed flag on timeout.
module alarm_ringer #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_TIME  = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input logic          clk_1hz,
    input logic          reset,
    alarm_ringer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT - 1);
    localparam logic [8:0] SNZ_LAST  = 9'(SNOOZE_TIME - 1);
    localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

    state_t     state_q, state_d;
    logic       trig_q, trig_d;
    logic       snz_q, snz_d;
    logic       armed_q, armed_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [8:0] snz_cnt_q, snz_cnt_d;
    logic       buzzer_q, buzzer_d;
    logic [2:0] snooze_count_q, snooze_count_d;
    logic       missed_q, missed_d;

    logic       trig_rise;
    logic       snz_rise;
    logic [7:0] ring_cnt_inc;
    logic [8:0] snz_cnt_inc;

    // A trigger already high when reset releases is not a fresh edge; armed_q
    // only allows a session once the trigger has been seen low.
    assign trig_rise    = bus.alarm_trigger & ~trig_q & armed_q;
    assign snz_rise     = bus.snooze_btn & ~snz_q;
    assign ring_cnt_inc = (ring_cnt_q == 8'hFF)  ? ring_cnt_q : ring_cnt_q + 8'd1;
    assign snz_cnt_inc  = (snz_cnt_q == 9'h1FF) ? snz_cnt_q  : snz_cnt_q + 9'd1;

    always_comb begin
        state_d        = state_q;
        trig_d         = bus.alarm_trigger;
        snz_d          = bus.snooze_btn;
        armed_d        = armed_q | ~bus.alarm_trigger;
        ring_cnt_d     = ring_cnt_q;
        snz_cnt_d      = snz_cnt_q;
        buzzer_d       = buzzer_q;
        snooze_count_d = snooze_count_q;
        missed_d       = missed_q;

        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d        = RINGING;
                    ring_cnt_d     = 8'd0;
                    snz_cnt_d      = 9'd0;
                    snooze_count_d = 3'd0;
                    missed_d       = 1'b0;
                    buzzer_d       = 1'b1;
                end
            end
            RINGING: begin
                if (bus.stop_btn) begin
                    state_d    = IDLE;
                    buzzer_d   = 1'b0;
                    ring_cnt_d = 8'd0;
                    snz_cnt_d  = 9'd0;
                end else if (snz_rise && (snooze_count_q < SNZ_MAX)) begin
                    state_d        = SNOOZE;
                    snooze_count_d = snooze_count_q + 3'd1;
                    buzzer_d       = 1'b0;
                    ring_cnt_d     = 8'd0;
                    snz_cnt_d      = 9'd0;
                end else if (ring_cnt_q == RING_LAST) begin
                    state_d    = IDLE;
                    missed_d   = 1'b1;
                    buzzer_d   = 1'b0;
                    ring_cnt_d = 8'd0;
                    snz_cnt_d  = 9'd0;
                end else begin
                    buzzer_d   = ~buzzer_q;
                    ring_cnt_d = ring_cnt_inc;
                end
            end
            SNOOZE: begin
                if (bus.stop_btn) begin
                    state_d    = IDLE;
                    buzzer_d   = 1'b0;
                    ring_cnt_d = 8'd0;
                    snz_cnt_d  = 9'd0;
                end else if (snz_cnt_q == SNZ_LAST) begin
                    state_d    = RINGING;
                    buzzer_d   = 1'b1;
                    ring_cnt_d = 8'd0;
                    snz_cnt_d  = 9'd0;
                end else begin
                    snz_cnt_d = snz_cnt_inc;
                end
            end
            default: begin
                state_d  = IDLE;
                buzzer_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1hz or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            trig_q         <= 1'b0;
            snz_q          <= 1'b0;
            armed_q        <= 1'b0;
            ring_cnt_q     <= 8'd0;
            snz_cnt_q      <= 9'd0;
            buzzer_q       <= 1'b0;
            snooze_count_q <= 3'd0;
            missed_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            trig_q         <= trig_d;
            snz_q          <= snz_d;
            armed_q        <= armed_d;
            ring_cnt_q     <= ring_cnt_d;
            snz_cnt_q      <= snz_cnt_d;
            buzzer_q       <= buzzer_d;
            snooze_count_q <= snooze_count_d;
            missed_q       <= missed_d;
        end
    end

    assign bus.buzzer       = buzzer_q;
    assign bus.ringing      = (state_q == RINGING);
    assign bus.snoozing     = (state_q == SNOOZE);
    assign bus.snooze_count = snooze_count_q;
    assign bus.alarm_missed = missed_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboard bench for alarm_ringer: the driver queues the expected outputs for
// each cycle it drives; the monitor pops and compares just after each edge.
module tb_alarm_ringer;

    typedef struct packed {
        logic       ringing;
        logic       snoozing;
        logic       buzzer;
        logic [2:0] cnt;
        logic       missed;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t  exp_q[$];
    string name_q[$];
    event  sample_ev;

    exp_t  mon_e;
    exp_t  mon_a;
    string mon_nm;

    alarm_ringer_if bus();

    alarm_ringer #(
        .RING_TIMEOUT(60),
        .SNOOZE_TIME (300),
        .MAX_SNOOZE  (3)
    ) dut (
        .clk_1hz(clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        -> sample_ev;
    end

    initial begin
        forever begin
            @(sample_ev);
            if (exp_q.size() != 0) begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                mon_a  = {bus.ringing, bus.snoozing, bus.buzzer, bus.snooze_count, bus.alarm_missed};
                n_vec++;
                if (mon_a !== mon_e)  begin
                    n_err++;
                    $display("FAIL %s @%0t: got ringing=%b snoozing=%b buzzer=%b cnt=%0d missed=%b, want ringing=%b snoozing=%b buzzer=%b cnt=%0d missed=%b",
                             mon_nm, $time, mon_a.ringing, mon_a.snoozing, mon_a.buzzer, mon_a.cnt, mon_a.missed,
                             mon_e.ringing, mon_e.snoozing, mon_e.buzzer, mon_e.cnt, mon_e.missed);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    function automatic exp_t ring(input logic b, input logic [2:0] c);
        exp_t e;
        e = {1'b1, 1'b0, b, c, 1'b0};
        return e;
    endfunction

    function automatic exp_t snz(input logic [2:0] c);
        exp_t e;
        e = {1'b0, 1'b1, 1'b0, c, 1'b0};
        return e;
    endfunction

    function automatic exp_t idl(input logic [2:0] c, input logic m);
        exp_t e;
        e = {1'b0, 1'b0, 1'b0, c, m};
        return e;
    endfunction

    task automatic step(input logic trig, input logic sb, input logic stop,
                        input exp_t e, input string nm);
        @(negedge clk);
        bus.alarm_trigger = trig;
        bus.snooze_btn    = sb;
        bus.stop_btn      = stop;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.alarm_trigger = 1'b0;
        bus.snooze_btn    = 1'b0;
        bus.stop_btn      = 1'b0;

        step(0, 0, 0, idl(0, 0), "reset_state");
        step(0, 0, 0, idl(0, 0), "reset_state");
        reset = 1'b1;

        // Plain timeout
        step(0, 0, 0, idl(0, 0), "idle_after_reset");
        step(1, 0, 0, ring(1, 0), "timeout_first");
        for (int k = 1; k < 60; k++) step(1, 0, 0, ring(k % 2 == 0, 0), "timeout_ring");
        for (int k = 0; k < 5; k++) step(1, 0, 0, idl(0, 1), "timeout_missed_no_restart");
        step(0, 0, 0, idl(0, 1), "timeout_trig_low");

        // Snooze cycle, then stop on ringing cycle 10
        step(1, 0, 0, ring(1, 0), "snooze_ring0");
        for (int k = 1; k < 5; k++) step(1, 0, 0, ring(k % 2 == 0, 0), "snooze_ring");
        step(1, 1, 0, snz(1), "snooze_enter");
        for (int j = 1; j < 300; j++) step(j >= 100, 0, 0, snz(1), "snooze_hold");
        step(1, 0, 0, ring(1, 1), "snooze_return");
        for (int k = 1; k < 10; k++) step(1, 0, 0, ring(k % 2 == 0, 1), "ring_after_snooze");
        step(1, 0, 1, idl(1, 0), "stop_ringing");
        step(1, 0, 0, idl(1, 0), "stop_no_restart");
        step(0, 0, 0, idl(1, 0), "stop_trig_low");

        // Snooze limit, button held high through each snooze
        step(1, 0, 0, ring(1, 0), "limit_ring0");
        for (int s = 1; s <= 3; s++) begin
            step(0, 0, 0, ring(0, 3'(s - 1)), "limit_ring1");
            step(0, 1, 0, snz(3'(s)), "limit_snooze_enter");
            for (int j = 1; j < 300; j++) step(0, 1, 0, snz(3'(s)), "limit_snooze_held");
            step(0, 1, 0, ring(1, 3'(s)), "limit_return_held");
        end
        step(0, 0, 0, ring(0, 3), "limit_ring1_final");
        step(0, 1, 0, ring(1, 3), "limit_fourth_ignored");
        for (int k = 3; k < 60; k++) step(0, k < 10, 0, ring(k % 2 == 0, 3), "limit_ring_on");
        step(0, 0, 0, idl(3, 1), "limit_timeout");

        // Stop during snooze
        step(1, 0, 0, ring(1, 0), "ssnz_ring0");
        step(1, 1, 0, snz(1), "ssnz_enter");
        for (int j = 0; j < 4; j++) step(1, 0, 0, snz(1), "ssnz_hold");
        step(1, 0, 1, idl(1, 0), "ssnz_stop");
        step(1, 0, 1, idl(1, 0), "ssnz_stop_held");
        step(0, 0, 0, idl(1, 0), "ssnz_trig_low");

        // Stop and snooze edge together
        step(1, 0, 0, ring(1, 0), "simul_ring0");
        step(1, 1, 1, idl(0, 0), "simul_stop_wins");
        step(0, 0, 0, idl(0, 0), "simul_trig_low");

        // Snooze edge on the timeout edge
        step(1, 0, 0, ring(1, 0), "tsnz_ring0");
        for (int k = 1; k < 60; k++) step(1, 0, 0, ring(k % 2 == 0, 0), "tsnz_ring");
        step(1, 1, 0, snz(1), "tsnz_snooze_wins");
        step(1, 0, 0, snz(1), "tsnz_hold");
        step(1, 0, 1, idl(1, 0), "tsnz_stop");
        step(0, 0, 0, idl(1, 0), "tsnz_trig_low");

        // Asynchronous reset during snooze
        step(1, 0, 0, ring(1, 0), "rst_ring0");
        step(1, 1, 0, snz(1), "rst_snooze_enter");
        for (int j = 0; j < 3; j++) step(1, 0, 0, snz(1), "rst_snooze_hold");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(idl(0, 0));
        name_q.push_back("async_reset");
        -> sample_ev;
        step(1, 0, 0, idl(0, 0), "in_reset");
        reset = 1'b1;
        for (int j = 0; j < 3; j++) step(1, 0, 0, idl(0, 0), "no_session_trig_high");
        step(0, 0, 0, idl(0, 0), "rearm_trig_low");
        step(1, 0, 0, ring(1, 0), "rearm_session");
        step(1, 0, 1, idl(0, 0), "rearm_stop");
        step(0, 0, 0, idl(0, 0), "final_idle");

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
